// File: rtl/seq_gen.sv
// seq_gen: seeded LFSR colour-sequence generator and LED player for the Genius game
module seq_gen #(
  parameter int NUM_COLORS = 4,
  parameter int DEPTH = 16,
  parameter int ON_CYCLES = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_game,
  input  logic [15:0]               seed,
  input  logic                      play,
  input  logic [$clog2(DEPTH):0]    length,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr,
  output logic [NUM_COLORS-1:0]     rd_color,
  output logic [NUM_COLORS-1:0]     led,
  output logic                      busy,
  output logic                      ready,
  output logic                      done
);
  localparam int CW = $clog2(NUM_COLORS);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2((ON_CYCLES > GAP_CYCLES ? ON_CYCLES : GAP_CYCLES) + 1);
  localparam logic [NUM_COLORS-1:0] ONE = {{(NUM_COLORS-1){1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE, GEN, ON, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] mem [DEPTH];
  logic [15:0] lfsr;
  logic [AW-1:0] idx;
  logic [LW-1:0] len, len_c;
  logic [TW-1:0] cnt;
  logic start_play, trivial, gen_end, on_end, gap_end, last_step;
  assign len_c = length > LW'(DEPTH) ? LW'(DEPTH) : length;
  assign start_play = state == IDLE && play && !new_game && ready && len_c != '0;
  assign trivial = state == IDLE && play && !new_game && !start_play;
  assign gen_end = idx == AW'(DEPTH - 1);
  assign on_end = cnt == TW'(ON_CYCLES - 1);
  assign gap_end = cnt == TW'(GAP_CYCLES - 1);
  assign last_step = {1'b0, idx} == len - LW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= 16'hACE1;
      idx <= '0;
      len <= '0;
      cnt <= '0;
      ready <= 1'b0;
      done <= 1'b0;
      rd_color <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + TW'(1);
      idx <= state == IDLE ? '0 : (state == GEN || (state == GAP && gap_end && !last_step)) ? idx + AW'(1) : idx;
      len <= start_play ? len_c : len;
      lfsr <= (state == IDLE && new_game) ? (seed == 16'h0 ? 16'hACE1 : seed) :
              state == GEN ? {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]} : lfsr;
      ready <= (state == IDLE && new_game) ? 1'b0 : (state == GEN && gen_end) ? 1'b1 : ready;
      done <= trivial || (state == GAP && gap_end && last_step);
      rd_color <= ready ? ONE << mem[rd_addr] : '0;
    end
  end
  // Memory is not reset; ready gates every read of it.
  always_ff @(posedge clk)
    if (state == GEN) mem[idx] <= lfsr[CW-1:0];
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = new_game ? GEN : start_play ? ON : IDLE;
      GEN:  state_n = gen_end ? IDLE : GEN;
      ON:   state_n = on_end ? GAP : ON;
      GAP:  state_n = gap_end ? (last_step ? IDLE : ON) : GAP;
    endcase
  end
  always_comb begin
    led = state == ON ? ONE << mem[idx] : '0;
    busy = state != IDLE;
  end
endmodule
